tile_fetch_addr_gen: RTL and testbench
======================================

Name: tile_fetch_addr_gen

Overview:
Downstream consumer of the tile controller's descriptor stream. It accepts one input-window descriptor per tile: signed origin row/col, window height/width. It walks the window in row-major order and emits one read beat per input pixel, carrying either a linear memory address or a zero-pad flag for out-of-image coordinates. Its output feeds the activation memory read port and the line-buffer writer.

Parameters:
DIM_W, 16, width of dimension/coordinate fields (matches tile controller)
ADDR_W, 24, width of linear pixel address

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_img_h  in  DIM_W  image height in pixels, sampled at tile accept
cfg_img_w  in  DIM_W  image width in pixels, sampled at tile accept
cfg_base_addr  in  ADDR_W  address of pixel (0,0), sampled at tile accept
tile_valid  in  1  descriptor valid
tile_ready  out  1  descriptor accept
tile_in_row  in  DIM_W+1  signed window origin row (may be negative)
tile_in_col  in  DIM_W+1  signed window origin col (may be negative)
tile_in_h  in  DIM_W  window height
tile_in_w  in  DIM_W  window width
rd_valid  out  1  read beat valid
rd_ready  in  1  read beat accept
rd_addr  out  ADDR_W  linear address; 0 when rd_pad=1
rd_pad  out  1  coordinate outside image; consumer writes zero
rd_local_row  out  DIM_W  row offset within window (0..h-1)
rd_local_col  out  DIM_W  col offset within window (0..w-1)
rd_last  out  1  final beat of tile
busy  out  1  high in RUN
tile_done  out  1  one-cycle pulse after tile completes

Behaviour:
- Reset is clk/rst_n, asynchronous, active-low. Reset values: state IDLE, rd_valid=0, rd_pad=0, rd_last=0, rd_addr=0, local counters 0, busy=0, tile_done=0. tile_ready=1, since it is combinational and high in IDLE.
- States are IDLE and RUN.
- IDLE: tile_ready=1. On tile_valid&&tile_ready, latch the descriptor, cfg_img_h/w and cfg_base_addr, and clear both counters.
  - If tile_in_h==0 or tile_in_w==0: stay IDLE, emit no beats, pulse tile_done in the next cycle.
  - Otherwise go to RUN. The first rd_valid appears the cycle after accept.
- RUN: tile_ready=0, rd_valid=1. Absolute coordinate is r=in_row+local_row, c=in_col+local_col, computed signed at DIM_W+2 bits.
- rd_pad=1 iff r<0 or r>=img_h or c<0 or c>=img_w.
- When rd_pad=0: rd_addr = base + r*img_w + c, modulo 2^ADDR_W. An incremental row-base register is permitted but must match this formula exactly.
- rd_last=1 iff local_row==h-1 and local_col==w-1.
- Beat advance on rd_valid&&rd_ready:
  - local_col++.
  - If local_col==w-1: local_col=0 and local_row++.
  - On the rd_last beat: go to IDLE, drop rd_valid next cycle, pulse tile_done for exactly one cycle next cycle.
- While rd_valid&&!rd_ready, all rd_* outputs are held stable.
- Throughput is one beat per cycle with rd_ready held high. A tile emits exactly h*w beats.
- Between tiles there is a minimum one-cycle bubble: the last beat is followed by an IDLE cycle in which the next descriptor can be accepted.
- Config inputs changing during RUN have no effect until the next accept.
- Reset mid-tile aborts immediately: the remaining beats are discarded and no tile_done is issued.

Test Plan:
1. Top-left halo tile: img 8x8, base 0x100, in_row=-1, in_col=-1, h=4, w=4, rd_ready=1.
   -> 16 beats on consecutive cycles.
   -> Beats 0..4 and all col=-1 beats have pad=1, addr=0.
   -> Beat (1,1) has addr 0x100; beat (3,3) has addr 0x112 with rd_last=1.
   -> tile_done pulses 1 cycle after beat 16.
2. Bottom-right overhang: img 8x8, base 0, in_row=6, in_col=6, h=3, w=3.
   -> Beat (0,0) addr=54, beat (1,1) addr=63.
   -> Local row 2 and local col 2 beats all pad=1.
   -> 9 beats total.
3. Backpressure: case 1 with rd_ready pseudo-random at 50%.
   -> rd_* stable during stalls.
   -> Address/pad sequence identical to case 1; exactly 16 accepted beats.
4. Zero-size tile: h=0, w=5 accepted.
   -> rd_valid never asserts; tile_done pulses on the cycle after accept; tile_ready stays 1.
5. Reset mid-tile: deassert rst_n after 5 beats of case 1.
   -> rd_valid=0, busy=0, tile_ready=1, no tile_done.
   -> A new descriptor after reset starts at local (0,0).
6. Back-to-back tiles: tile_valid held with two descriptors.
   -> Second accept occurs in the IDLE cycle right after the first rd_last beat.
   -> Exactly one idle cycle between the streams; 2 tile_done pulses.

Source files
------------

// File: rtl/tile_fetch_addr_gen_if.sv
// Handshake bundles around the tile fetch address generator.
// tile_desc_if carries one input-window descriptor per tile from the tile
// controller; tile_rd_if carries the per-pixel read beats to the activation
// memory read port and line-buffer writer.

interface tile_desc_if #(
   parameter int DIM_W = 16
);
   logic             tile_valid;
   logic             tile_ready;
   logic [DIM_W:0]   tile_in_row;   // signed origin row
   logic [DIM_W:0]   tile_in_col;   // signed origin col
   logic [DIM_W-1:0] tile_in_h;
   logic [DIM_W-1:0] tile_in_w;

   modport master (
      output tile_valid, tile_in_row, tile_in_col, tile_in_h, tile_in_w,
      input  tile_ready
   );

   modport slave (
      input  tile_valid, tile_in_row, tile_in_col, tile_in_h, tile_in_w,
      output tile_ready
   );
endinterface

interface tile_rd_if #(
   parameter int DIM_W  = 16,
   parameter int ADDR_W = 24
);
   logic              rd_valid;
   logic              rd_ready;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_pad;
   logic [DIM_W-1:0]  rd_local_row;
   logic [DIM_W-1:0]  rd_local_col;
   logic              rd_last;

   modport master (
      output rd_valid, rd_addr, rd_pad, rd_local_row, rd_local_col, rd_last,
      input  rd_ready
   );

   modport slave (
      input  rd_valid, rd_addr, rd_pad, rd_local_row, rd_local_col, rd_last,
      output rd_ready
   );
endinterface

// File: rtl/tile_fetch_addr_gen.sv
// Tile fetch address generator: accepts one input-window descriptor, walks
// the window row-major and emits one read beat per pixel, either a linear
// address or a zero-pad flag for coordinates outside the image.
// All rd_* outputs are registered; the beat for the next counter position is
// computed combinationally and loaded on accept or on each accepted beat.

module tile_fetch_addr_gen #(
   parameter int DIM_W  = 16,
   parameter int ADDR_W = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DIM_W-1:0]  cfg_img_h,
   input  logic [DIM_W-1:0]  cfg_img_w,
   input  logic [ADDR_W-1:0] cfg_base_addr,
   tile_desc_if.slave        tile,
   tile_rd_if.master         rd,
   output logic              busy,
   output logic              tile_done
);

   // Signed coordinate width: origin (DIM_W+1 signed) plus an unsigned offset.
   localparam int CW = DIM_W + 2;
   localparam int PW = 2 * DIM_W;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t            r_state;
   logic [DIM_W:0]    r_in_row;
   logic [DIM_W:0]    r_in_col;
   logic [DIM_W-1:0]  r_h;
   logic [DIM_W-1:0]  r_w;
   logic [DIM_W-1:0]  r_img_h;
   logic [DIM_W-1:0]  r_img_w;
   logic [ADDR_W-1:0] r_base;
   logic [DIM_W-1:0]  r_lrow;
   logic [DIM_W-1:0]  r_lcol;
   logic              r_rd_valid;
   logic [ADDR_W-1:0] r_rd_addr;
   logic              r_rd_pad;
   logic              r_rd_last;
   logic              r_busy;
   logic              r_tile_done;

   logic              w_idle;
   logic [DIM_W:0]    w_org_row;
   logic [DIM_W:0]    w_org_col;
   logic [DIM_W-1:0]  w_img_h;
   logic [DIM_W-1:0]  w_img_w;
   logic [ADDR_W-1:0] w_base;
   logic [DIM_W-1:0]  w_h;
   logic [DIM_W-1:0]  w_w;
   logic [DIM_W-1:0]  w_lrow;
   logic [DIM_W-1:0]  w_lcol;
   logic [CW-1:0]     w_r;
   logic [CW-1:0]     w_c;
   logic              w_pad;
   logic [PW-1:0]     w_prod;
   logic [ADDR_W-1:0] w_addr;
   logic              w_last;
   logic              w_zero;

   assign w_idle          = (r_state == S_IDLE);
   assign tile.tile_ready = w_idle;

   assign rd.rd_valid     = r_rd_valid;
   assign rd.rd_addr      = r_rd_addr;
   assign rd.rd_pad       = r_rd_pad;
   assign rd.rd_last      = r_rd_last;
   assign rd.rd_local_row = r_lrow;
   assign rd.rd_local_col = r_lcol;
   assign busy            = r_busy;
   assign tile_done       = r_tile_done;

   // Next-beat computation: in IDLE it describes beat (0,0) of the incoming
   // descriptor, in RUN the beat after the one currently presented.
   always_comb begin
      w_org_row = w_idle ? tile.tile_in_row : r_in_row;
      w_org_col = w_idle ? tile.tile_in_col : r_in_col;
      w_img_h   = w_idle ? cfg_img_h        : r_img_h;
      w_img_w   = w_idle ? cfg_img_w        : r_img_w;
      w_base    = w_idle ? cfg_base_addr    : r_base;
      w_h       = w_idle ? tile.tile_in_h   : r_h;
      w_w       = w_idle ? tile.tile_in_w   : r_w;
      w_zero    = (tile.tile_in_h == '0) || (tile.tile_in_w == '0);

      w_lrow = '0;
      w_lcol = '0;
      if (!w_idle) begin
         if (r_lcol == r_w - DIM_W'(1)) begin
            w_lcol = '0;
            w_lrow = r_lrow + DIM_W'(1);
         end else begin
            w_lcol = r_lcol + DIM_W'(1);
            w_lrow = r_lrow;
         end
      end

      // Two's-complement sum; sign bit marks a negative absolute coordinate.
      w_r = {w_org_row[DIM_W], w_org_row} + {2'b00, w_lrow};
      w_c = {w_org_col[DIM_W], w_org_col} + {2'b00, w_lcol};

      // Once known non-negative, the low CW-1 bits hold the magnitude.
      w_pad = w_r[CW-1] || w_c[CW-1] ||
              (w_r[CW-2:0] >= {1'b0, w_img_h}) ||
              (w_c[CW-2:0] >= {1'b0, w_img_w});

      // In-image coordinates fit DIM_W bits; the address wraps modulo 2^ADDR_W.
      w_prod = PW'(w_r[DIM_W-1:0]) * PW'(w_img_w);
      w_addr = w_pad ? '0 :
               (w_base + ADDR_W'(w_prod) + ADDR_W'(w_c[DIM_W-1:0]));

      w_last = (w_lrow == w_h - DIM_W'(1)) && (w_lcol == w_w - DIM_W'(1));
   end

   // Control FSM with registered beat outputs and completion pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_in_row    <= '0;
         r_in_col    <= '0;
         r_h         <= '0;
         r_w         <= '0;
         r_img_h     <= '0;
         r_img_w     <= '0;
         r_base      <= '0;
         r_lrow      <= '0;
         r_lcol      <= '0;
         r_rd_valid  <= 1'b0;
         r_rd_addr   <= '0;
         r_rd_pad    <= 1'b0;
         r_rd_last   <= 1'b0;
         r_busy      <= 1'b0;
         r_tile_done <= 1'b0;
      end else begin
         r_tile_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (tile.tile_valid) begin
                  r_in_row <= tile.tile_in_row;
                  r_in_col <= tile.tile_in_col;
                  r_h      <= tile.tile_in_h;
                  r_w      <= tile.tile_in_w;
                  r_img_h  <= cfg_img_h;
                  r_img_w  <= cfg_img_w;
                  r_base   <= cfg_base_addr;
                  r_lrow   <= '0;
                  r_lcol   <= '0;
                  if (w_zero) begin
                     // Empty window: nothing to stream, report completion.
                     r_tile_done <= 1'b1;
                  end else begin
                     r_state    <= S_RUN;
                     r_busy     <= 1'b1;
                     r_rd_valid <= 1'b1;
                     r_rd_addr  <= w_addr;
                     r_rd_pad   <= w_pad;
                     r_rd_last  <= w_last;
                  end
               end
            end
            S_RUN: begin
               if (rd.rd_ready) begin
                  if (r_rd_last) begin
                     r_state     <= S_IDLE;
                     r_busy      <= 1'b0;
                     r_rd_valid  <= 1'b0;
                     r_rd_addr   <= '0;
                     r_rd_pad    <= 1'b0;
                     r_rd_last   <= 1'b0;
                     r_tile_done <= 1'b1;
                  end else begin
                     r_lrow    <= w_lrow;
                     r_lcol    <= w_lcol;
                     r_rd_addr <= w_addr;
                     r_rd_pad  <= w_pad;
                     r_rd_last <= w_last;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tile_fetch_addr_gen.sv
// Directed scoreboard bench for tile_fetch_addr_gen.

module tb_tile_fetch_addr_gen;

   localparam int DIM_W  = 16;
   localparam int ADDR_W = 24;

   typedef struct {
      int                lrow;
      int                lcol;
      logic              pad;
      logic [ADDR_W-1:0] addr;
      logic              last;
   } beat_t;

   logic              clk;
   logic              rst_n;
   logic [DIM_W-1:0]  cfg_img_h;
   logic [DIM_W-1:0]  cfg_img_w;
   logic [ADDR_W-1:0] cfg_base_addr;
   logic              busy;
   logic              tile_done;

   tile_desc_if #(.DIM_W(DIM_W)) desc ();
   tile_rd_if #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) rdi ();

   tile_fetch_addr_gen #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_img_h     (cfg_img_h),
      .cfg_img_w     (cfg_img_w),
      .cfg_base_addr (cfg_base_addr),
      .tile          (desc),
      .rd            (rdi),
      .busy          (busy),
      .tile_done     (tile_done)
   );

   int    total = 0;
   int    bad   = 0;
   int    cyc   = 0;
   beat_t exp_q[$];
   int    beats_seen = 0;
   int    done_cnt = 0;
   int    done_exp_cyc = -1;
   int    first_beat_cyc = -1;
   int    last_beat_cyc = -1;
   int    gap = -1;
   bit    rand_ready = 0;
   bit    stall_hold = 0;
   logic [ADDR_W+2*DIM_W+2:0] held;

   initial clk = 0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: one entry per window pixel, row-major.
   task automatic push_tile(input int ih, input int iw, input int base,
                            input int row, input int col, input int h, input int w);
      for (int lr = 0; lr < h; lr++) begin
         for (int lc = 0; lc < w; lc++) begin
            beat_t b;
            int r;
            int c;
            r = row + lr;
            c = col + lc;
            b.lrow = lr;
            b.lcol = lc;
            b.pad  = (r < 0) || (r >= ih) || (c < 0) || (c >= iw);
            b.addr = b.pad ? '0 : ADDR_W'(base + r * iw + c);
            b.last = (lr == h - 1) && (lc == w - 1);
            exp_q.push_back(b);
         end
      end
   endtask

   // Present a descriptor until accepted, then scramble cfg/descriptor inputs.
   task automatic send_tile(input int ih, input int iw, input int base,
                            input int row, input int col, input int h, input int w);
      bit ok;
      ok = 0;
      cfg_img_h        = DIM_W'(ih);
      cfg_img_w        = DIM_W'(iw);
      cfg_base_addr    = ADDR_W'(base);
      desc.tile_in_row = (DIM_W+1)'(row);
      desc.tile_in_col = (DIM_W+1)'(col);
      desc.tile_in_h   = DIM_W'(h);
      desc.tile_in_w   = DIM_W'(w);
      desc.tile_valid  = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (desc.tile_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("accept_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      desc.tile_valid  = 1'b0;
      cfg_img_h        = DIM_W'($urandom);
      cfg_img_w        = DIM_W'($urandom);
      cfg_base_addr    = ADDR_W'($urandom);
      desc.tile_in_row = (DIM_W+1)'($urandom);
      desc.tile_in_col = (DIM_W+1)'($urandom);
      desc.tile_in_h   = DIM_W'($urandom);
      desc.tile_in_w   = DIM_W'($urandom);
   endtask

   task automatic wait_drain(input int budget);
      bit ok;
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #2;
         if (exp_q.size() == 0 && done_exp_cyc == -1) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         check("drain_timeout", 64'd0, 64'd1);
         exp_q.delete();
         done_exp_cyc = -1;
      end
   endtask

   task automatic wait_beats(input int n, input int budget);
      bit ok;
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #2;
         if (beats_seen >= n) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("beats_timeout", 64'(beats_seen), 64'(n));
   endtask

   // rd_ready driver: always-ready or a 50% coin flip per cycle.
   initial begin
      rdi.rd_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         rdi.rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: pops scoreboard on each handshake, checks stall stability
   // and tile_done timing.
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_hold = 0;
      end else begin
         if (stall_hold)
            check("stall_stable",
                  64'({rdi.rd_valid, rdi.rd_addr, rdi.rd_pad, rdi.rd_local_row,
                       rdi.rd_local_col, rdi.rd_last}), 64'(held));
         if (rdi.rd_valid && !rdi.rd_ready) begin
            stall_hold = 1;
            held = {rdi.rd_valid, rdi.rd_addr, rdi.rd_pad, rdi.rd_local_row,
                    rdi.rd_local_col, rdi.rd_last};
         end else begin
            stall_hold = 0;
         end
         if (rdi.rd_valid && rdi.rd_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 64'd1, 64'd0);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               check("beat_row",  64'(rdi.rd_local_row), 64'(e.lrow));
               check("beat_col",  64'(rdi.rd_local_col), 64'(e.lcol));
               check("beat_pad",  64'(rdi.rd_pad),       64'(e.pad));
               check("beat_addr", 64'(rdi.rd_addr),      64'(e.addr));
               check("beat_last", 64'(rdi.rd_last),      64'(e.last));
               beats_seen++;
               if (e.lrow == 0 && e.lcol == 0) begin
                  if (last_beat_cyc >= 0) gap = cyc - last_beat_cyc;
                  first_beat_cyc = cyc;
               end
               if (e.last) begin
                  last_beat_cyc = cyc;
                  done_exp_cyc  = cyc + 1;
               end
            end
         end
         if (desc.tile_valid && desc.tile_ready &&
             (desc.tile_in_h == '0 || desc.tile_in_w == '0))
            done_exp_cyc = cyc + 1;
         if (tile_done) begin
            done_cnt++;
            check("tile_done_time", 64'(cyc), 64'(done_exp_cyc));
            done_exp_cyc = -1;
         end
      end
   end

   initial begin
      int d0;
      rst_n            = 1'b0;
      cfg_img_h        = '0;
      cfg_img_w        = '0;
      cfg_base_addr    = '0;
      desc.tile_valid  = 1'b0;
      desc.tile_in_row = '0;
      desc.tile_in_col = '0;
      desc.tile_in_h   = '0;
      desc.tile_in_w   = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_rd_valid",   64'(rdi.rd_valid),     64'd0);
      check("rst_rd_pad",     64'(rdi.rd_pad),       64'd0);
      check("rst_rd_last",    64'(rdi.rd_last),      64'd0);
      check("rst_rd_addr",    64'(rdi.rd_addr),      64'd0);
      check("rst_local_row",  64'(rdi.rd_local_row), 64'd0);
      check("rst_local_col",  64'(rdi.rd_local_col), 64'd0);
      check("rst_busy",       64'(busy),             64'd0);
      check("rst_tile_done",  64'(tile_done),        64'd0);
      check("rst_tile_ready", 64'(desc.tile_ready),  64'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: top-left halo tile, full throughput
      beats_seen = 0; d0 = done_cnt;
      push_tile(8, 8, 'h100, -1, -1, 4, 4);
      send_tile(8, 8, 'h100, -1, -1, 4, 4);
      check("c1_busy", 64'(busy), 64'd1);
      check("c1_tile_ready_run", 64'(desc.tile_ready), 64'd0);
      wait_drain(100);
      check("c1_beats", 64'(beats_seen), 64'd16);
      check("c1_consecutive", 64'(last_beat_cyc - first_beat_cyc), 64'd15);
      check("c1_done_cnt", 64'(done_cnt - d0), 64'd1);
      check("c1_idle_busy", 64'(busy), 64'd0);

      // 2: bottom-right overhang
      beats_seen = 0; d0 = done_cnt;
      push_tile(8, 8, 0, 6, 6, 3, 3);
      send_tile(8, 8, 0, 6, 6, 3, 3);
      wait_drain(100);
      check("c2_beats", 64'(beats_seen), 64'd9);
      check("c2_done_cnt", 64'(done_cnt - d0), 64'd1);

      // 3: case 1 under random backpressure
      beats_seen = 0; d0 = done_cnt;
      rand_ready = 1;
      push_tile(8, 8, 'h100, -1, -1, 4, 4);
      send_tile(8, 8, 'h100, -1, -1, 4, 4);
      wait_drain(400);
      rand_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      check("c3_beats", 64'(beats_seen), 64'd16);
      check("c3_done_cnt", 64'(done_cnt - d0), 64'd1);

      // 4: zero-size tile
      beats_seen = 0; d0 = done_cnt;
      send_tile(8, 8, 0, 0, 0, 0, 5);
      check("c4_ready_after_accept", 64'(desc.tile_ready), 64'd1);
      wait_drain(20);
      repeat (3) @(posedge clk);
      #1;
      check("c4_beats", 64'(beats_seen), 64'd0);
      check("c4_done_cnt", 64'(done_cnt - d0), 64'd1);
      check("c4_tile_ready", 64'(desc.tile_ready), 64'd1);

      // 5: reset mid-tile after 5 beats
      beats_seen = 0; d0 = done_cnt;
      push_tile(8, 8, 'h100, -1, -1, 4, 4);
      send_tile(8, 8, 'h100, -1, -1, 4, 4);
      wait_beats(5, 100);
      rst_n = 1'b0;
      #1;
      check("c5_rd_valid", 64'(rdi.rd_valid), 64'd0);
      check("c5_busy", 64'(busy), 64'd0);
      check("c5_tile_ready", 64'(desc.tile_ready), 64'd1);
      exp_q.delete();
      done_exp_cyc = -1;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("c5_no_done", 64'(done_cnt - d0), 64'd0);
      check("c5_idle_rd_valid", 64'(rdi.rd_valid), 64'd0);
      beats_seen = 0;
      push_tile(8, 8, 'h100, -1, -1, 4, 4);
      send_tile(8, 8, 'h100, -1, -1, 4, 4);
      wait_drain(100);
      check("c5_restart_beats", 64'(beats_seen), 64'd16);

      // 6: back-to-back tiles with tile_valid held
      beats_seen = 0; d0 = done_cnt;
      last_beat_cyc = -1; gap = -1;
      push_tile(8, 8, 'h100, -1, -1, 4, 4);
      push_tile(8, 8, 0, 6, 6, 3, 3);
      send_tile(8, 8, 'h100, -1, -1, 4, 4);
      send_tile(8, 8, 0, 6, 6, 3, 3);
      wait_drain(200);
      check("c6_beats", 64'(beats_seen), 64'd25);
      check("c6_gap", 64'(gap), 64'd2);
      check("c6_done_cnt", 64'(done_cnt - d0), 64'd2);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
